// File: rtl/axi_main_memory.sv
// Word-addressed AXI-style backing store; independent read and write burst engines (`AXI_MEM_PROTOCOL_CHECK_EN adds a sticky W-channel checker).
// Latency: first R beat READ_LATENCY cycles after AR handshake (+1 cycle to visibility); B one cycle after the final W beat.
// Backpressure: R beat and B held until RREADY/BREADY; READY outputs depend only on registered state.
module axi_main_memory #(
    parameter int ADDR_WIDTH   = 26,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_WORDS    = 16384,
    parameter int READ_LATENCY = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [3:0]            AWID,
    input  logic [3:0]            AWLEN,
    input  logic [ADDR_WIDTH-1:0] AWADDR,
    input  logic                  WVALID,
    output logic                  WREADY,
    input  logic                  WLAST,
    input  logic [3:0]            WID,
    input  logic [DATA_WIDTH-1:0] WDATA,
    output logic                  BVALID,
    input  logic                  BREADY,
    output logic [3:0]            BID,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [3:0]            ARID,
    input  logic [3:0]            ARLEN,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  RLAST,
    output logic [3:0]            RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic                  protocol_error
);
    localparam int IW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic          init_done_q;
    rstate_t       rstate_q, rstate_d;
    logic [3:0]    rid_q, rid_d, rlen_q, rlen_d, rbeat_q, rbeat_d, rcnt_q, rcnt_d;
    logic [IW-1:0] rbase_q, rbase_d, ridx;
    wstate_t       wstate_q, wstate_d;
    logic [3:0]    wid_q, wid_d, wlen_q, wlen_d, wbeat_q, wbeat_d;
    logic [IW-1:0] wbase_q, wbase_d, widx;
    logic          wr_en;

    // Address arithmetic truncates to the array index width, giving wrap to word 0.
    assign ridx  = rbase_q + IW'(rbeat_q);
    assign widx  = wbase_q + IW'(wbeat_q);
    assign wr_en = (wstate_q == W_DATA) && WVALID;

    always_ff @(posedge clk) begin
        if (wr_en) mem[widx] <= WDATA;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_done_q <= 1'b0;
            rstate_q    <= R_IDLE;
            rid_q       <= '0;
            rlen_q      <= '0;
            rbeat_q     <= '0;
            rcnt_q      <= '0;
            rbase_q     <= '0;
            wstate_q    <= W_IDLE;
            wid_q       <= '0;
            wlen_q      <= '0;
            wbeat_q     <= '0;
            wbase_q     <= '0;
        end else begin
            init_done_q <= 1'b1;
            rstate_q    <= rstate_d;
            rid_q       <= rid_d;
            rlen_q      <= rlen_d;
            rbeat_q     <= rbeat_d;
            rcnt_q      <= rcnt_d;
            rbase_q     <= rbase_d;
            wstate_q    <= wstate_d;
            wid_q       <= wid_d;
            wlen_q      <= wlen_d;
            wbeat_q     <= wbeat_d;
            wbase_q     <= wbase_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        rlen_d   = rlen_q;
        rbeat_d  = rbeat_q;
        rcnt_d   = rcnt_q;
        rbase_d  = rbase_q;
        ARREADY  = 1'b0;
        RVALID   = 1'b0;
        RLAST    = 1'b0;
        RID      = '0;
        RDATA    = '0;
        case (rstate_q)
            R_IDLE: begin
                ARREADY = init_done_q;
                if (ARVALID && init_done_q) begin
                    rid_d    = ARID;
                    rlen_d   = ARLEN;
                    rbase_d  = ARADDR[IW-1:0];
                    rbeat_d  = '0;
                    rcnt_d   = 4'(READ_LATENCY);
                    rstate_d = (READ_LATENCY == 0) ? R_BURST : R_WAIT;
                end
            end
            R_WAIT: begin
                rcnt_d = rcnt_q - 4'd1;
                if (rcnt_q <= 4'd1) rstate_d = R_BURST;
            end
            R_BURST: begin
                // RDATA reads the array live so a stalled beat tracks writes to its word.
                RVALID = 1'b1;
                RID    = rid_q;
                RDATA  = mem[ridx];
                RLAST  = (rbeat_q == rlen_q);
                if (RREADY) begin
                    rbeat_d = rbeat_q + 4'd1;
                    if (rbeat_q == rlen_q) rstate_d = R_IDLE;
                end
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        wlen_d   = wlen_q;
        wbeat_d  = wbeat_q;
        wbase_d  = wbase_q;
        AWREADY  = 1'b0;
        WREADY   = 1'b0;
        BVALID   = 1'b0;
        BID      = '0;
        case (wstate_q)
            W_IDLE: begin
                AWREADY = init_done_q;
                if (AWVALID && init_done_q) begin
                    wid_d    = AWID;
                    wlen_d   = AWLEN;
                    wbase_d  = AWADDR[IW-1:0];
                    wbeat_d  = '0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                // Burst length comes from the beat count; WLAST is not consulted.
                WREADY = 1'b1;
                if (WVALID) begin
                    wbeat_d = wbeat_q + 4'd1;
                    if (wbeat_q == wlen_q) wstate_d = W_RESP;
                end
            end
            W_RESP: begin
                BVALID = 1'b1;
                BID    = wid_q;
                if (BREADY) wstate_d = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    logic unused_addr;
    assign unused_addr = ^{ARADDR[ADDR_WIDTH-1:IW], AWADDR[ADDR_WIDTH-1:IW]};

`ifdef AXI_MEM_PROTOCOL_CHECK_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (wr_en && ((WLAST != (wbeat_q == wlen_q)) || (WID != wid_q))) perr_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perr_q <= 1'b0;
        else        perr_q <= perr_d;
    end

    assign protocol_error = perr_q;

`ifdef SIMULATION
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(RREADY && !RVALID)) else $error("RREADY high without RVALID");
            assert (!(BREADY && !BVALID)) else $error("BREADY high without BVALID");
        end
    end
`endif
`else
    logic unused_chk;
    assign unused_chk     = ^{WID, WLAST};
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_axi_main_memory.sv
// Bench for axi_main_memory: table of write/read-back bursts checked through a read scoreboard,
// plus hand-written reset, concurrency, mid-burst reset and checker sequences.
module tb_axi_main_memory;
    localparam int AW  = 26;
    localparam int DW  = 32;
    localparam int MW  = 16384;
    localparam int RL  = 4;
    localparam int LIM = 100;

    logic          clk, rst_n;
    logic          AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
    logic          ARVALID, ARREADY, RVALID, RREADY, RLAST, protocol_error;
    logic [3:0]    AWID, AWLEN, WID, BID, ARID, ARLEN, RID;
    logic [AW-1:0] AWADDR, ARADDR;
    logic [DW-1:0] WDATA, RDATA;

    axi_main_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(MW), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWID(AWID), .AWLEN(AWLEN), .AWADDR(AWADDR),
        .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST), .WID(WID), .WDATA(WDATA),
        .BVALID(BVALID), .BREADY(BREADY), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARID(ARID), .ARLEN(ARLEN), .ARADDR(ARADDR),
        .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST), .RID(RID), .RDATA(RDATA),
        .protocol_error(protocol_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DW-1:0] dat;
        logic [3:0]    id;
        logic          last;
    } beat_t;

    typedef struct {
        logic [3:0]    wid;
        logic [3:0]    rid;
        logic [AW-1:0] addr;
        logic [3:0]    len;
        logic [DW-1:0] seed;
        logic [15:0]   rpat;
        logic [DW-1:0] exp_last;
    } vec_t;

    beat_t         sbq[$];
    logic [DW-1:0] model [int];

`ifdef AXI_MEM_PROTOCOL_CHECK_EN
    localparam logic PERR_EXP = 1'b1;
`else
    localparam logic PERR_EXP = 1'b0;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_write(input logic [3:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                            input logic [DW-1:0] seed, input logic bad_last);
        int n;
        AWVALID = 1'b1; AWID = id; AWADDR = addr; AWLEN = len;
        n = 0;
        while (!AWREADY && n < LIM) begin @(negedge clk); n++; end
        chk("aw_handshake_bound", 64'(n < LIM), 1);
        @(posedge clk); @(negedge clk);
        AWVALID = 1'b0;
        chk("wready_after_aw", WREADY, 1);
        for (int i = 0; i <= int'(len); i++) begin
            WVALID = 1'b1; WDATA = seed + DW'(i); WID = id;
            WLAST  = bad_last ? (i == 1) : (i == int'(len));
            n = 0;
            while (!WREADY && n < LIM) begin @(negedge clk); n++; end
            @(posedge clk);
            model[(int'(addr) + i) % MW] = seed + DW'(i);
            @(negedge clk);
        end
        WVALID = 1'b0; WLAST = 1'b0;
        chk("bvalid_after_last_w", BVALID, 1);
        chk("bid", BID, id);
        BREADY = 1'b1;
        @(posedge clk); @(negedge clk);
        BREADY = 1'b0;
        chk("awready_after_b", AWREADY, 1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [AW-1:0] addr, input logic [3:0] len,
                           input logic [15:0] pat, output logic [DW-1:0] last_dat);
        int n, lat, k;
        beat_t e;
        logic have_prev;
        logic [DW-1:0] prev_dat;
        logic [3:0] prev_id;
        last_dat = '0;
        ARVALID = 1'b1; ARID = id; ARADDR = addr; ARLEN = len;
        n = 0;
        while (!ARREADY && n < LIM) begin @(negedge clk); n++; end
        chk("ar_handshake_bound", 64'(n < LIM), 1);
        @(posedge clk);
        for (int i = 0; i <= int'(len); i++)
            sbq.push_back('{model[(int'(addr) + i) % MW], id, (i == int'(len))});
        lat = 1;
        @(negedge clk);
        ARVALID = 1'b0;
        while (!RVALID && lat < 40) begin @(posedge clk); lat++; @(negedge clk); end
        chk("read_latency", 64'(lat), 64'(RL + 1));
        k = 0; have_prev = 1'b0; prev_dat = '0; prev_id = '0;
        while (sbq.size() > 0 && k < 300) begin
            if (!RVALID) begin
                chk("rvalid_in_burst", RVALID, 1);
                break;
            end
            if (have_prev) begin
                chk("stall_rdata_stable", RDATA, prev_dat);
                chk("stall_rid_stable", RID, prev_id);
            end
            RREADY = pat[k % 16];
            if (RREADY) begin
                e = sbq.pop_front();
                chk("rdata", RDATA, e.dat);
                chk("rid", RID, e.id);
                chk("rlast", RLAST, e.last);
                last_dat  = RDATA;
                have_prev = 1'b0;
            end else begin
                prev_dat  = RDATA;
                prev_id   = RID;
                have_prev = 1'b1;
            end
            @(posedge clk); @(negedge clk);
            RREADY = 1'b0;
            k++;
        end
        chk("scoreboard_drained", 64'(sbq.size()), 0);
        sbq.delete();
        chk("rvalid_after_burst", RVALID, 0);
        chk("arready_after_rlast", ARREADY, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vec_t vt [5];
        logic [DW-1:0] d;
        int n;

        vt[0] = '{4'd2, 4'd5, 26'h10,      4'd3,  32'hA0,  16'hFFFF, 32'hA3};
        vt[1] = '{4'd7, 4'd9, 26'(MW - 1), 4'd1,  32'hB0,  16'hFFFF, 32'hB1};
        vt[2] = '{4'd1, 4'd3, 26'h100,     4'd15, 32'hC00, 16'h9999, 32'hC0F};
        vt[3] = '{4'hF, 4'hE, 26'h2000040, 4'd0,  32'hD0,  16'hFFFF, 32'hD0};
        vt[4] = '{4'd4, 4'd6, 26'(MW - 3), 4'd5,  32'hE0,  16'h00F1, 32'hE5};

        rst_n = 1'b0;
        AWVALID = 0; AWID = 0; AWLEN = 0; AWADDR = 0;
        WVALID = 0; WLAST = 0; WID = 0; WDATA = 0; BREADY = 0;
        ARVALID = 0; ARID = 0; ARLEN = 0; ARADDR = 0; RREADY = 0;
        repeat (3) @(negedge clk);
        chk("rst_readys", {AWREADY, WREADY, ARREADY}, 0);
        chk("rst_valids", {BVALID, RVALID, RLAST}, 0);
        chk("rst_ids", {BID, RID}, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_perr", protocol_error, 0);
        rst_n = 1'b1;
        #1;
        chk("arready_first_cycle", {ARREADY, AWREADY}, 0);
        @(posedge clk); @(negedge clk);
        chk("arready_second_cycle", {ARREADY, AWREADY}, 2'b11);

        for (int i = 0; i < 5; i++) begin
            do_write(vt[i].wid, vt[i].addr, vt[i].len, vt[i].seed, 1'b0);
            do_read(vt[i].rid, vt[i].addr, vt[i].len, vt[i].rpat, d);
            chk("vec_last_beat", d, vt[i].exp_last);
            if (i == 1) begin
                do_read(4'd9, 26'h0, 4'd0, 16'hFFFF, d);
                chk("wrap_word0", d, 32'hB1);
            end
        end
        chk("perr_clean", protocol_error, 0);

        // Same-cycle read/write of word 0x20 while the read beat is held.
        do_write(4'd3, 26'h20, 4'd0, 32'h11, 1'b0);
        ARVALID = 1'b1; ARID = 4'd8; ARADDR = 26'h20; ARLEN = 4'd0;
        n = 0;
        while (!ARREADY && n < LIM) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < LIM) begin @(negedge clk); n++; end
        chk("conc_rvalid", RVALID, 1);
        chk("conc_pre", RDATA, 32'h11);
        AWVALID = 1'b1; AWID = 4'd3; AWADDR = 26'h20; AWLEN = 4'd0;
        n = 0;
        while (!AWREADY && n < LIM) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        AWVALID = 1'b0;
        WVALID = 1'b1; WDATA = 32'h55; WID = 4'd3; WLAST = 1'b1;
        chk("conc_wready", WREADY, 1);
        chk("conc_same_cycle_old", RDATA, 32'h11);
        @(posedge clk); @(negedge clk);
        WVALID = 1'b0; WLAST = 1'b0;
        chk("conc_held_new", RDATA, 32'h55);
        chk("conc_rid", RID, 4'd8);
        BREADY = 1'b1;
        @(posedge clk); @(negedge clk);
        BREADY = 1'b0;
        RREADY = 1'b1;
        @(posedge clk); @(negedge clk);
        RREADY = 1'b0;
        chk("conc_r_done", RVALID, 0);
        model[32'h20] = 32'h55;
        do_read(4'd8, 26'h20, 4'd0, 16'hFFFF, d);
        chk("conc_reread", d, 32'h55);

        // Reset while a read burst is presenting beats.
        ARVALID = 1'b1; ARID = 4'd1; ARADDR = 26'h10; ARLEN = 4'd3;
        n = 0;
        while (!ARREADY && n < LIM) begin @(negedge clk); n++; end
        @(posedge clk); @(negedge clk);
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < LIM) begin @(negedge clk); n++; end
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", {RVALID, ARREADY, RLAST}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_beats", RVALID, 0);
        chk("midrst_arready", ARREADY, 1);

        do_write(4'd2, 26'h300, 4'd3, 32'hF0, 1'b1);
        chk("perr_bad_wlast", protocol_error, PERR_EXP);
        do_write(4'd2, 26'h304, 4'd1, 32'hF8, 1'b0);
        do_read(4'd2, 26'h300, 4'd5, 16'hFFFF, d);
        chk("bad_wlast_data_intact", d, 32'hF9);
        chk("perr_sticky", protocol_error, PERR_EXP);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
